// File: rtl/sketch_banked.sv
// sketch_banked: count-min sketch over NUM_HASH synchronous-read counter rows with
// write-back forwarding and a sweep engine (clear; decay when SKETCH_DECAY_EN is defined).
module sketch_banked #(
    parameter int W         = 4096,
    parameter int NUM_HASH  = 4,
    parameter int HASH_SIZE = $clog2(W),
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32,
    parameter int WGT_SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic                          input_query,
    input  logic [WGT_SIZE-1:0]           input_weight,
    input  logic [ADDR_SIZE-1:0]          input_addr,
    input  logic [NUM_HASH*HASH_SIZE-1:0] input_hash_array,
    input  logic                          clear_req,
    input  logic                          decay_req,
    output logic                          busy,
    output logic                          sweep_done,
    output logic                          output_valid,
    output logic [ADDR_SIZE-1:0]          output_addr,
    output logic [NUM_HASH*CNT_SIZE-1:0]  output_cnt_array,
    output logic [CNT_SIZE-1:0]           output_min,
    output logic                          output_sat
);
    localparam int STAGES = 2;
    localparam logic [HASH_SIZE:0] K_ONE      = (HASH_SIZE+1)'(1);
    localparam logic [HASH_SIZE:0] K_CLR_LAST = (HASH_SIZE+1)'(W-1);

`ifdef SKETCH_DECAY_EN
    localparam logic [HASH_SIZE:0] K_DEC_LAST = (HASH_SIZE+1)'(W);
    typedef enum logic [2:0] {IDLE, DRAIN, CLEAR, DECAY, DONE} state_t;
    logic op_decay;
    logic sweep_half;
`else
    typedef enum logic [2:0] {IDLE, DRAIN, CLEAR, DONE} state_t;
    logic unused_decay;
    assign unused_decay = decay_req;
`endif

    state_t                              state, state_nx;
    logic [HASH_SIZE:0]                  sweep_k, sweep_k_nx;
    logic                                sweep_we;
    logic [HASH_SIZE-1:0]                sweep_addr;
    logic                                accept;
    logic [STAGES:1]                     vld_pipe;
    logic                                s1_query;
    logic [WGT_SIZE-1:0]                 s1_weight;
    logic [ADDR_SIZE-1:0]                s1_addr;
    logic [NUM_HASH-1:0][HASH_SIZE-1:0]  s1_hash, s2_hash, rd_addr;
    logic [NUM_HASH-1:0][CNT_SIZE-1:0]   new_cnt;
    logic [CNT_SIZE-1:0]                 min_cnt;
    logic                                any_sat;

    assign accept       = input_valid && input_ready;
    assign busy         = (state != IDLE);
    assign sweep_done   = (state == DONE);
    assign output_valid = vld_pipe[STAGES];

    always_comb begin
        rd_addr = input_hash_array;
`ifdef SKETCH_DECAY_EN
        if (state == DECAY)
            for (int r = 0; r < NUM_HASH; r++) rd_addr[r] = sweep_k[HASH_SIZE-1:0];
`endif
    end

    always_comb begin
        state_nx   = state;
        sweep_k_nx = sweep_k;
        sweep_we   = 1'b0;
        sweep_addr = sweep_k[HASH_SIZE-1:0];
`ifdef SKETCH_DECAY_EN
        sweep_half = 1'b0;
`endif
        case (state)
            IDLE: begin
                sweep_k_nx = '0;
                if (clear_req) state_nx = DRAIN;
`ifdef SKETCH_DECAY_EN
                else if (decay_req) state_nx = DRAIN;
`endif
            end
            // S2 only holds registered outputs; once S1 has written back the rows are stable.
            DRAIN: if (!vld_pipe[1]) begin
`ifdef SKETCH_DECAY_EN
                state_nx = op_decay ? DECAY : CLEAR;
`else
                state_nx = CLEAR;
`endif
            end
            CLEAR: begin
                sweep_we   = 1'b1;
                sweep_k_nx = sweep_k + K_ONE;
                if (sweep_k == K_CLR_LAST) state_nx = DONE;
            end
`ifdef SKETCH_DECAY_EN
            // Read index k while writing back the halved value of index k-1.
            DECAY: begin
                sweep_we   = (sweep_k != '0);
                sweep_half = 1'b1;
                sweep_addr = HASH_SIZE'(sweep_k - K_ONE);
                sweep_k_nx = sweep_k + K_ONE;
                if (sweep_k == K_DEC_LAST) state_nx = DONE;
            end
`endif
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sweep_k     <= '0;
            input_ready <= 1'b0;
`ifdef SKETCH_DECAY_EN
            op_decay    <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            sweep_k     <= sweep_k_nx;
            input_ready <= (state_nx == IDLE);
`ifdef SKETCH_DECAY_EN
            if (state == IDLE) op_decay <= decay_req && !clear_req;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe         <= '0;
            s1_query         <= 1'b0;
            s1_weight        <= '0;
            s1_addr          <= '0;
            s1_hash          <= '0;
            s2_hash          <= '0;
            output_addr      <= '0;
            output_cnt_array <= '0;
            output_min       <= '0;
            output_sat       <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept) begin
                s1_query  <= input_query;
                s1_weight <= input_weight;
                s1_addr   <= input_addr;
                s1_hash   <= input_hash_array;
            end
            if (vld_pipe[1]) begin
                s2_hash          <= s1_hash;
                output_addr      <= s1_addr;
                output_cnt_array <= new_cnt;
                output_min       <= min_cnt;
                output_sat       <= any_sat;
            end
        end
    end

    always_comb begin
        min_cnt = new_cnt[0];
        any_sat = 1'b0;
        for (int r = 0; r < NUM_HASH; r++) begin
            if (new_cnt[r] < min_cnt) min_cnt = new_cnt[r];
            if (new_cnt[r] == '1) any_sat = 1'b1;
        end
    end

    // The S2 result is the registered output, so it doubles as the forwarding source.
    sketch_banked_row #(
        .W(W), .HASH_SIZE(HASH_SIZE), .CNT_SIZE(CNT_SIZE), .WGT_SIZE(WGT_SIZE)
    ) u_row [NUM_HASH-1:0] (
        .clk        (clk),
        .raddr      (rd_addr),
        .s1_vld     (vld_pipe[1]),
        .s1_query   (s1_query),
        .s1_idx     (s1_hash),
        .s1_weight  (s1_weight),
        .s2_vld     (vld_pipe[2]),
        .s2_idx     (s2_hash),
        .s2_cnt     (output_cnt_array),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
`ifdef SKETCH_DECAY_EN
        .sweep_half (sweep_half),
`endif
        .new_cnt    (new_cnt)
    );
endmodule

// One sketch row: W-deep single-write synchronous-read counter array plus its
// forwarding and saturating-add datapath.
module sketch_banked_row #(
    parameter int W         = 4096,
    parameter int HASH_SIZE = $clog2(W),
    parameter int CNT_SIZE  = 32,
    parameter int WGT_SIZE  = 4
) (
    input  logic                 clk,
    input  logic [HASH_SIZE-1:0] raddr,
    input  logic                 s1_vld,
    input  logic                 s1_query,
    input  logic [HASH_SIZE-1:0] s1_idx,
    input  logic [WGT_SIZE-1:0]  s1_weight,
    input  logic                 s2_vld,
    input  logic [HASH_SIZE-1:0] s2_idx,
    input  logic [CNT_SIZE-1:0]  s2_cnt,
    input  logic                 sweep_we,
    input  logic [HASH_SIZE-1:0] sweep_addr,
`ifdef SKETCH_DECAY_EN
    input  logic                 sweep_half,
`endif
    output logic [CNT_SIZE-1:0]  new_cnt
);
    logic [CNT_SIZE-1:0]  mem [W];
    logic [CNT_SIZE-1:0]  rdata, old_cnt, wdata, sweep_wdata;
    logic [CNT_SIZE:0]    sum;
    logic                 we;
    logic [HASH_SIZE-1:0] waddr;

    // Raw read-during-write is stale; the previous request's result covers that case.
    assign old_cnt = (s2_vld && s2_idx == s1_idx) ? s2_cnt : rdata;
    assign sum     = {1'b0, old_cnt} + (CNT_SIZE+1)'(s1_weight);
    assign new_cnt = s1_query ? old_cnt : (sum[CNT_SIZE] ? '1 : sum[CNT_SIZE-1:0]);

`ifdef SKETCH_DECAY_EN
    assign sweep_wdata = sweep_half ? (rdata >> 1) : '0;
`else
    assign sweep_wdata = '0;
`endif

    assign we    = sweep_we || (s1_vld && !s1_query);
    assign waddr = sweep_we ? sweep_addr : s1_idx;
    assign wdata = sweep_we ? sweep_wdata : new_cnt;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: tb/tb_sketch_banked.sv
// Bench for sketch_banked: directed steps plus random traffic against a per-row array model.
module tb_sketch_banked;
    localparam int W = 16, NH = 4, HS = 4, AS = 22, CS = 4, WS = 4;
    localparam int CMAX = (1 << CS) - 1;

    logic clk = 1'b0;
    logic rst;
    logic input_valid, input_ready, input_query;
    logic [WS-1:0] input_weight;
    logic [AS-1:0] input_addr;
    logic [NH*HS-1:0] input_hash_array;
    logic clear_req, decay_req, busy, sweep_done, output_valid, output_sat;
    logic [AS-1:0] output_addr;
    logic [NH*CS-1:0] output_cnt_array;
    logic [CS-1:0] output_min;

    sketch_banked #(.W(W), .NUM_HASH(NH), .HASH_SIZE(HS), .ADDR_SIZE(AS),
                    .CNT_SIZE(CS), .WGT_SIZE(WS)) dut (
        .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(input_ready),
        .input_query(input_query), .input_weight(input_weight), .input_addr(input_addr),
        .input_hash_array(input_hash_array), .clear_req(clear_req), .decay_req(decay_req),
        .busy(busy), .sweep_done(sweep_done), .output_valid(output_valid),
        .output_addr(output_addr), .output_cnt_array(output_cnt_array),
        .output_min(output_min), .output_sat(output_sat));

    always #5 clk = ~clk;

    typedef struct packed {
        int            due;
        logic [AS-1:0] addr;
        logic [NH*CS-1:0] cnt;
        logic [CS-1:0] mn;
        logic          sat;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   mdl [NH][W];
    int   errors = 0, checks = 0, cyc = 0, low_cnt = 0;
    bit   fresh = 1'b0, have_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshake state, model any accepted request or sweep, then check outputs.
    task automatic tick();
        bit exp_rdy, acc, dec;
        int drain, nxt, idx, mn, sum;
        exp_t e;
        exp_rdy = (low_cnt == 0) && !fresh;
        chk("input_ready", input_ready, exp_rdy);
        chk("busy", busy, low_cnt > 0);
        chk("sweep_done", sweep_done, low_cnt == 1);
        acc = input_valid && exp_rdy;
        if (acc) begin
            e = '0;
            e.due = cyc + 2;
            e.addr = input_addr;
            mn = CMAX;
            for (int r = 0; r < NH; r++) begin
                idx = int'(input_hash_array[r*HS +: HS]);
                if (!input_query) begin
                    sum = mdl[r][idx] + int'(input_weight);
                    mdl[r][idx] = (sum > CMAX) ? CMAX : sum;
                end
                e.cnt[r*CS +: CS] = CS'(mdl[r][idx]);
                if (mdl[r][idx] < mn) mn = mdl[r][idx];
                if (mdl[r][idx] == CMAX) e.sat = 1'b1;
            end
            e.mn = CS'(mn);
            q.push_back(e);
        end
        drain = acc ? 2 : 1;
        dec = 1'b0;
`ifdef SKETCH_DECAY_EN
        dec = (low_cnt == 0) && decay_req && !clear_req;
`endif
        if (low_cnt == 0 && clear_req) begin
            for (int r = 0; r < NH; r++) for (int k = 0; k < W; k++) mdl[r][k] = 0;
            nxt = W + drain + 1;
        end else if (dec) begin
            for (int r = 0; r < NH; r++) for (int k = 0; k < W; k++) mdl[r][k] = mdl[r][k] / 2;
            nxt = W + 1 + drain + 1;
        end else begin
            nxt = (low_cnt > 0) ? low_cnt - 1 : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        low_cnt = nxt;
        fresh = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("output_valid", output_valid, 1'b1);
            chk("output_addr", output_addr, e.addr);
            chk("output_cnt_array", output_cnt_array, e.cnt);
            chk("output_min", output_min, e.mn);
            chk("output_sat", output_sat, e.sat);
            last = e;
            have_last = 1'b1;
        end else begin
            chk("output_valid_idle", output_valid, 1'b0);
            if (have_last) begin
                chk("hold_cnt", output_cnt_array, last.cnt);
                chk("hold_min", output_min, last.mn);
            end
        end
    endtask

    task automatic req(input bit qry, input int w, input logic [AS-1:0] a, input logic [NH*HS-1:0] h);
        input_valid = 1'b1;
        input_query = qry;
        input_weight = WS'(w);
        input_addr = a;
        input_hash_array = h;
    endtask

    task automatic settle();
        input_valid = 1'b0;
        clear_req = 1'b0;
        decay_req = 1'b0;
        for (int n = 0; n < 200 && (low_cnt > 0 || q.size() > 0); n++) tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        input_valid = 1'b0;
        clear_req = 1'b0;
        decay_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_input_ready", input_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sweep_done", sweep_done, 1'b0);
        chk("rst_output_valid", output_valid, 1'b0);
        chk("rst_output_addr", output_addr, '0);
        chk("rst_output_cnt", output_cnt_array, '0);
        chk("rst_output_min", output_min, '0);
        chk("rst_output_sat", output_sat, 1'b0);
        rst = 1'b0;
        fresh = 1'b1;
        low_cnt = 0;
        q.delete();
        have_last = 1'b0;
    endtask

    initial begin
        logic [NH*HS-1:0] h;
        rst = 1'b1; input_valid = 1'b0; input_query = 1'b0; input_weight = '0;
        input_addr = '0; input_hash_array = '0; clear_req = 1'b0; decay_req = 1'b0;
        do_reset();
        clear_req = 1'b1; tick(); settle();

        // Three back-to-back increments of one address.
        for (int i = 0; i < 3; i++) begin req(0, 1, 22'h10, {4'd3, 4'd2, 4'd1, 4'd0}); tick(); end
        settle();

        // A, B, A with row 0 shared between A and B.
        req(0, 1, 22'hA, {4'd9, 4'd8, 4'd7, 4'd5}); tick();
        req(0, 1, 22'hB, {4'd12, 4'd11, 4'd10, 4'd5}); tick();
        req(0, 1, 22'hA, {4'd9, 4'd8, 4'd7, 4'd5}); tick();
        settle();

        // Saturation: weight 4 five times.
        for (int i = 0; i < 5; i++) begin req(0, 4, 22'h2F, {4'd15, 4'd15, 4'd15, 4'd15}); tick(); end
        settle();

        // Update then two queries.
        req(0, 3, 22'h33, {4'd6, 4'd6, 4'd6, 4'd6}); tick();
        req(1, 0, 22'h33, {4'd6, 4'd6, 4'd6, 4'd6}); tick();
        settle();
        req(1, 5, 22'h33, {4'd6, 4'd6, 4'd6, 4'd6}); tick();
        settle();

        // Clear with a request accepted in the same cycle, then query.
        req(0, 2, 22'h44, {4'd6, 4'd6, 4'd6, 4'd6}); clear_req = 1'b1; tick();
        settle();
        req(1, 0, 22'h44, {4'd6, 4'd6, 4'd6, 4'd6}); tick();
        req(1, 0, 22'h2F, {4'd15, 4'd15, 4'd15, 4'd15}); tick();
        settle();

        // Decay of a count of 7, then simultaneous clear and decay.
        req(0, 7, 22'h55, {4'd2, 4'd2, 4'd2, 4'd2}); tick();
        settle();
        decay_req = 1'b1; tick(); settle();
        req(1, 0, 22'h55, {4'd2, 4'd2, 4'd2, 4'd2}); tick();
        settle();
        req(0, 7, 22'h56, {4'd3, 4'd3, 4'd3, 4'd3}); tick();
        settle();
        clear_req = 1'b1; decay_req = 1'b1; tick(); settle();
        req(1, 0, 22'h56, {4'd3, 4'd3, 4'd3, 4'd3}); tick();
        settle();

        // Random traffic with occasional sweep requests.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NH; r++) h[r*HS +: HS] = HS'($urandom_range(0, 7));
            req($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), AS'($urandom), h);
            input_valid = ($urandom_range(0, 3) != 0);
            clear_req = ($urandom_range(0, 59) == 0);
            decay_req = ($urandom_range(0, 39) == 0);
            tick();
        end
        settle();

        // Reset in the middle of a clear sweep, then recover.
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (4) tick();
        do_reset();
        tick();
        clear_req = 1'b1; tick(); settle();
        for (int i = 0; i < 20; i++) begin
            for (int r = 0; r < NH; r++) h[r*HS +: HS] = HS'($urandom_range(0, 3));
            req($urandom_range(0, 2) == 0, int'($urandom_range(0, 2)), AS'($urandom), h);
            tick();
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
